// File: rtl/spike_log_pkg.sv
// spike_log_pkg: shared constants and the event record type for the spike
// event logger.
//
// Contents:
//   TS_WIDTH_DEF / DEPTH_DEF / VMEM_WIDTH_DEF  default sizes
//   SAT_MAX        saturation ceiling for the 8-bit counters
//   spike_event_t  one FIFO record: timestamp, plus the pre-spike membrane
//                  value when SPIKE_LOG_VMEM_EN is defined
//   sat_inc        saturating 8-bit increment helper
//
// Optional feature macro: SPIKE_LOG_VMEM_EN (adds the vmem field).
package spike_log_pkg;

    localparam int TS_WIDTH_DEF   = 12;
    localparam int DEPTH_DEF      = 8;
    localparam int VMEM_WIDTH_DEF = 16;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    // Record widths follow the package defaults; the top-level TS_WIDTH and
    // VMEM_WIDTH parameters default to the same values.
    typedef struct packed {
        logic [TS_WIDTH_DEF-1:0]   ts;
`ifdef SPIKE_LOG_VMEM_EN
        logic [VMEM_WIDTH_DEF-1:0] vmem;
`endif
    } spike_event_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic inc);
        return (inc && (value != SAT_MAX)) ? value + 8'd1 : value;
    endfunction

endpackage

// File: rtl/spike_log_fifo.sv
// spike_log_fifo: synchronous show-ahead FIFO of spike_event_t records.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   push      write din this cycle (ignored when full unless popping too)
//   din       record to write
//   pop       consume the head record (ignored when empty)
//   dout      head record, zero while empty
//   full      level == DEPTH
//   empty     level == 0
//   level     occupancy, 0..DEPTH
//
// Pointers are $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of
// two); fullness comes from the separate occupancy counter.
module spike_log_fifo
    import spike_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  spike_event_t             din,
    input  logic                     pop,
    output spike_event_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    spike_event_t          mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // When full, a simultaneous pop frees the head slot; the write lands in
    // that same slot (wr_ptr == rd_ptr) after the head has been consumed.
    assign push_ok = push && (!full || pop_ok);
    assign level   = count;

    // Gating on empty keeps stale RAM contents off the outputs after reset.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_event_logger.sv
// spike_event_logger: timestamps LIF-core spikes into a show-ahead FIFO
// drained by valid/ready, tracks dropped spikes, and reports a windowed
// spike-rate count.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       global enable; low holds ts/window counters, ignores spikes
//   spike_in     spike pulse, sampled each cycle
//   v_mem_in     membrane potential (used only with SPIKE_LOG_VMEM_EN)
//   ev_valid     head event present
//   ev_ready     consumer accepts head event
//   ev_ts        head event timestamp
//   ev_vmem      head event pre-spike membrane (0 without SPIKE_LOG_VMEM_EN)
//   ev_level     FIFO occupancy
//   overflow     sticky drop flag
//   clear_ovf    clears overflow and drop_cnt (a same-cycle drop wins)
//   drop_cnt     saturating dropped-spike count
//   rate_count   spikes in the last completed window, saturating
//   rate_valid   one-cycle pulse when rate_count updates
//
// Optional feature macro: SPIKE_LOG_VMEM_EN.
module spike_event_logger
    import spike_log_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int VMEM_WIDTH = VMEM_WIDTH_DEF,
    parameter int WINDOW     = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    spike_in,
    input  logic [VMEM_WIDTH-1:0]   v_mem_in,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [TS_WIDTH-1:0]     ev_ts,
    output logic [VMEM_WIDTH-1:0]   ev_vmem,
    output logic [$clog2(DEPTH):0]  ev_level,
    output logic                    overflow,
    input  logic                    clear_ovf,
    output logic [7:0]              drop_cnt,
    output logic [7:0]              rate_count,
    output logic                    rate_valid
);

    localparam int WW = $clog2(WINDOW);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

    logic [TS_WIDTH-1:0] ts;
    logic [WW-1:0]       win_cnt;
    logic [7:0]          spike_acc;
    logic [7:0]          acc_next;

    logic                push_req;
    logic                pop_eff;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    spike_event_t        push_ev;
    spike_event_t        head_ev;

    assign push_req = enable && spike_in;
    assign pop_eff  = ev_ready && !fifo_empty;
    // Dropped only when full and the head is not leaving this cycle.
    assign drop     = push_req && fifo_full && !pop_eff;
    assign acc_next = sat_inc(spike_acc, spike_in);

    assign ev_valid = !fifo_empty;
    assign ev_ts    = head_ev.ts;

`ifdef SPIKE_LOG_VMEM_EN
    // Membrane sampled one enabled cycle earlier: the core resets v_mem on
    // the spiking cycle, so the previous sample is the pre-fire value.
    logic [VMEM_WIDTH-1:0] vmem_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vmem_prev <= '0;
        end else if (enable) begin
            vmem_prev <= v_mem_in;
        end
    end

    always_comb begin
        push_ev      = '0;
        push_ev.ts   = ts;
        push_ev.vmem = vmem_prev;
    end

    assign ev_vmem = head_ev.vmem;
`else
    logic unused_vmem;
    assign unused_vmem = ^v_mem_in;

    always_comb begin
        push_ev    = '0;
        push_ev.ts = ts;
    end

    assign ev_vmem = '0;
`endif

    spike_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req && !drop),
        .din   (push_ev),
        .pop   (pop_eff),
        .dout  (head_ev),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (ev_level)
    );

    // Drop tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clear_ovf ? 8'd1 : sat_inc(drop_cnt, 1'b1);
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // Timestamp and rate window; everything here freezes while enable is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            win_cnt    <= '0;
            spike_acc  <= '0;
            rate_count <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= 1'b0;
            if (enable) begin
                ts <= ts + 1'b1;
                if (win_cnt == WIN_LAST) begin
                    rate_count <= acc_next;
                    rate_valid <= 1'b1;
                    win_cnt    <= '0;
                    spike_acc  <= '0;
                end else begin
                    win_cnt   <= win_cnt + 1'b1;
                    spike_acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_event_logger.sv
module tb_spike_event_logger;

    localparam int DEPTH  = 8;
    localparam int WINDOW = 256;
    localparam int TS_MOD = 4096;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        spike_in;
    logic [15:0] v_mem_in;
    logic        ev_valid;
    logic        ev_ready;
    logic [11:0] ev_ts;
    logic [15:0] ev_vmem;
    logic [3:0]  ev_level;
    logic        overflow;
    logic        clear_ovf;
    logic [7:0]  drop_cnt;
    logic [7:0]  rate_count;
    logic        rate_valid;

    spike_event_logger dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .spike_in   (spike_in),
        .v_mem_in   (v_mem_in),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_ts      (ev_ts),
        .ev_vmem    (ev_vmem),
        .ev_level   (ev_level),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .drop_cnt   (drop_cnt),
        .rate_count (rate_count),
        .rate_valid (rate_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int ts;
        int vmem;
    } ev_t;

    ev_t q[$];          // expected FIFO contents; pushed by model, popped by monitor
    int  m_ts, m_win, m_acc, m_rate, m_drop, m_vprev;
    bit  m_ovf, m_rate_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ts = 0; m_win = 0; m_acc = 0; m_rate = 0; m_drop = 0; m_vprev = 0;
            m_ovf = 0; m_rate_valid = 0;
        end else begin
            bit dropped;
            int acc_plus;
            ev_t e;
            dropped = 0;
            m_rate_valid = 0;
            if (enable && spike_in) begin
                if (q.size() < DEPTH) begin
                    e.ts = m_ts;
`ifdef SPIKE_LOG_VMEM_EN
                    e.vmem = m_vprev;
`else
                    e.vmem = 0;
`endif
                    q.push_back(e);
                end else begin
                    dropped = 1;
                end
            end
            if (dropped) begin
                m_ovf  = 1;
                m_drop = clear_ovf ? 1 : ((m_drop >= 255) ? 255 : m_drop + 1);
            end else if (clear_ovf) begin
                m_ovf  = 0;
                m_drop = 0;
            end
            if (enable) begin
                acc_plus = m_acc + (spike_in ? 1 : 0);
                if (acc_plus > 255) acc_plus = 255;
                if (m_win == WINDOW - 1) begin
                    m_rate = acc_plus;
                    m_rate_valid = 1;
                    m_win = 0;
                    m_acc = 0;
                end else begin
                    m_win = m_win + 1;
                    m_acc = acc_plus;
                end
                m_ts = (m_ts + 1) % TS_MOD;
                m_vprev = v_mem_in;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int last_rate = -1;
    int rate_pulses = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("ev_valid", ev_valid, (q.size() != 0));
            check("ev_level", ev_level, q.size());
            check("overflow", overflow, m_ovf);
            check("drop_cnt", drop_cnt, m_drop);
            check("rate_valid", rate_valid, m_rate_valid);
            check("rate_count", rate_count, m_rate);
            if (q.size() != 0) begin
                check("ev_ts", ev_ts, q[0].ts);
                check("ev_vmem", ev_vmem, q[0].vmem);
                if (ev_ready) void'(q.pop_front());
            end
            if (rate_valid) begin
                last_rate = rate_count;
                rate_pulses++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ev_valid"}, ev_valid, 0);
        check({tag, "_ev_ts"}, ev_ts, 0);
        check({tag, "_ev_vmem"}, ev_vmem, 0);
        check({tag, "_ev_level"}, ev_level, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_rate_count"}, rate_count, 0);
        check({tag, "_rate_valid"}, rate_valid, 0);
    endtask

    initial begin
        int guard;
        int en_cnt;
        rst = 1'b1; enable = 1'b0; spike_in = 1'b0; v_mem_in = '0;
        ev_ready = 1'b0; clear_ovf = 1'b0;
        #2;
        check_zero("reset");
        cyc(); cyc();
        rst = 1'b0;
        enable = 1'b1;

        // First spike at ts=5, one-cycle latency, then pop.
        guard = 0;
        while (m_ts != 5 && guard < 100) begin cyc(); guard++; end
        check("reach_ts5", m_ts, 5);
        spike_in = 1'b1; cyc(); spike_in = 1'b0;
        check("first_valid", ev_valid, 1);
        check("first_ts", ev_ts, 5);
        check("first_level", ev_level, 1);
        ev_ready = 1'b1; cyc(); ev_ready = 1'b0;
        check("first_popped", ev_valid, 0);

        // Ten back-to-back spikes into an empty FIFO: eight stored, two dropped.
        spike_in = 1'b1;
        repeat (10) cyc();
        spike_in = 1'b0;
        check("fill_level", ev_level, 8);
        check("fill_ovf", overflow, 1);
        check("fill_drops", drop_cnt, 2);

        // Full with simultaneous pop and push: accepted, level stays 8.
        spike_in = 1'b1; ev_ready = 1'b1; cyc();
        spike_in = 1'b0; ev_ready = 1'b0;
        check("fullpp_level", ev_level, 8);
        check("fullpp_drops", drop_cnt, 2);

        // clear_ovf in the same cycle as a drop: the drop wins.
        spike_in = 1'b1; clear_ovf = 1'b1; cyc();
        spike_in = 1'b0; clear_ovf = 1'b0;
        check("clrdrop_ovf", overflow, 1);
        check("clrdrop_cnt", drop_cnt, 1);
        clear_ovf = 1'b1; cyc(); clear_ovf = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_cnt", drop_cnt, 0);

        ev_ready = 1'b1;
        repeat (10) cyc();
        check("drained", ev_valid, 0);

        // Spike every 4th enabled cycle with an enable gap mid-phase.
        rate_pulses = 0;
        en_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            enable   = !(i >= 100 && i < 120);
            spike_in = enable && (en_cnt % 4 == 0);
            cyc();
            if (enable) en_cnt++;
        end
        enable = 1'b1; spike_in = 1'b0;
        check("rate_pulses_ge2", (rate_pulses >= 2), 1);
        check("rate_64", last_rate, 64);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom % 8) != 0;
            spike_in  = ($urandom % 3) == 0;
            ev_ready  = $urandom % 2;
            clear_ovf = ($urandom % 50) == 0;
            v_mem_in  = 16'($urandom);
            cyc();
        end
        enable = 1'b1; spike_in = 1'b0; clear_ovf = 1'b0; ev_ready = 1'b1;
        repeat (10) cyc();
        ev_ready = 1'b0;

        // Timestamp wrap: spikes at 4095 then 0, with a marked membrane value.
        guard = 0;
        v_mem_in = 16'h0000;
        while (m_ts != 4094 && guard < 5000) begin cyc(); guard++; end
        check("reach_ts4094", m_ts, 4094);
        v_mem_in = 16'h00FF; cyc();
        v_mem_in = 16'h1234; spike_in = 1'b1; cyc();
        cyc();
        spike_in = 1'b0;
        check("wrap_level", ev_level, 2);
        check("wrap_ts_a", ev_ts, 4095);
`ifdef SPIKE_LOG_VMEM_EN
        check("wrap_vmem", ev_vmem, 16'h00FF);
`else
        check("wrap_vmem", ev_vmem, 0);
`endif
        ev_ready = 1'b1; cyc(); ev_ready = 1'b0;
        check("wrap_ts_b", ev_ts, 0);
        ev_ready = 1'b1; cyc();

        // Three queued events with overflow set, then asynchronous reset.
        ev_ready = 1'b0; spike_in = 1'b1;
        repeat (9) cyc();
        spike_in = 1'b0; ev_ready = 1'b1;
        repeat (5) cyc();
        ev_ready = 1'b0;
        check("pre_rst_level", ev_level, 3);
        check("pre_rst_ovf", overflow, 1);
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        cyc();
        rst = 1'b0;
        cyc();
        check("post_rst_valid", ev_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
